imm_instr_encoder: RTL and testbench

Pipelined instruction encoder for the RISC-V datapath. It packs an immediate, register indices, funct3 and opcode into a 32-bit instruction word, which is the inverse of the immediate-extension step in decode. The block range-checks and alignment-checks the immediate against the selected format. It serves the instruction-memory loader and self-check benches, with valid/ready handshakes on both sides.

---
 rtl/riscv_imm_pkg.sv | 25 ++
 rtl/imm_field_pack.sv | 55 +++++
 rtl/imm_instr_encoder.sv | 86 ++++++++
 tb/tb_imm_instr_encoder.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_imm_pkg.sv
// Shared RV32I immediate format and encoder error codes, common to the encoder and the decode extend logic.
package riscv_imm_pkg;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_J = 3'b010;
   localparam logic [2:0] IMM_B = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_RANGE = 2'd1;
   localparam logic [1:0] ERR_ALIGN = 2'd2;
   localparam logic [1:0] ERR_FMT   = 2'd3;

   typedef struct packed {
      logic [2:0]  imm_src;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [31:0] imm;
   } imm_req_t;

endpackage

// File: rtl/imm_field_pack.sv
// Combinational packing of an immediate request into an RV32I word, with range/alignment/format checks.
// Zero latency; no flow control of its own.
module imm_field_pack
   import riscv_imm_pkg::*;
(
   input  imm_req_t    req,
   output logic [31:0] instr,
   output logic [1:0]  err
);

   logic range_bad;
   logic align_bad;
   logic fmt_bad;

   always_comb begin
      instr     = '0;
      range_bad = 1'b0;
      align_bad = 1'b0;
      fmt_bad   = 1'b0;
      case (req.imm_src)
         IMM_I: begin
            instr     = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
            range_bad = ~((&req.imm[31:11]) | ~(|req.imm[31:11]));
         end
         IMM_S: begin
            instr     = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], req.opcode};
            range_bad = ~((&req.imm[31:11]) | ~(|req.imm[31:11]));
         end
         IMM_B: begin
            instr     = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                         req.imm[4:1], req.imm[11], req.opcode};
            range_bad = ~((&req.imm[31:12]) | ~(|req.imm[31:12]));
            align_bad = req.imm[0];
         end
         IMM_U: begin
            instr     = {req.imm[31:12], req.rd, req.opcode};
            range_bad = |req.imm[11:0];
         end
         IMM_J: begin
            instr     = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12], req.rd, req.opcode};
            range_bad = ~((&req.imm[31:20]) | ~(|req.imm[31:20]));
            align_bad = req.imm[0];
         end
         default: begin
            fmt_bad = 1'b1;
         end
      endcase
   end

   // Bad format outranks range, which outranks misalignment.
   assign err = fmt_bad   ? ERR_FMT   :
                range_bad ? ERR_RANGE :
                align_bad ? ERR_ALIGN : ERR_NONE;

endmodule

// File: rtl/imm_instr_encoder.sv
// Two-stage RV32I instruction encoder, 2-cycle latency, 1/cycle throughput; holds up to 2 requests under
// out_ready backpressure. Define IMM_ENC_ERR_COUNT_EN to add the saturating err_cnt output.
module imm_instr_encoder
   import riscv_imm_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  imm_src,
   input  logic [6:0]  opcode,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic [31:0] imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] instr,
   output logic [1:0]  err
`ifdef IMM_ENC_ERR_COUNT_EN
   ,
   output logic [15:0] err_cnt
`endif
);

   imm_req_t    s1_req;
   logic        s1_valid;
   logic        s2_valid;
   logic        s2_load;
   logic        in_fire;
   logic        out_fire;
   logic [31:0] pk_instr;
   logic [1:0]  pk_err;

   assign s2_load   = s1_valid & (~s2_valid | out_ready);
   assign in_ready  = ~s1_valid | (~s2_valid | out_ready);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = s2_valid & out_ready;
   assign out_valid = s2_valid;

   imm_field_pack u_pack (
      .req   (s1_req),
      .instr (pk_instr),
      .err   (pk_err)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_req   <= '0;
      end else if (in_fire) begin
         s1_valid <= 1'b1;
         s1_req   <= '{imm_src: imm_src, opcode: opcode, rd: rd, rs1: rs1,
                       rs2: rs2, funct3: funct3, imm: imm};
      end else if (s2_load) begin
         s1_valid <= 1'b0;
      end
   end

   // S2 only reloads when empty or draining, so instr/err hold steady while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         instr    <= '0;
         err      <= ERR_NONE;
      end else if (s2_load) begin
         s2_valid <= 1'b1;
         instr    <= pk_instr;
         err      <= pk_err;
      end else if (out_fire) begin
         s2_valid <= 1'b0;
      end
   end

`ifdef IMM_ENC_ERR_COUNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (out_fire && (err != ERR_NONE) && (err_cnt != 16'hFFFF)) begin
         err_cnt <= err_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Scoreboard bench for imm_instr_encoder: directed vectors, randomized traffic, backpressure and mid-run reset.
module tb_imm_instr_encoder;

   typedef struct {
      logic [2:0]  src;
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [31:0] imm;
   } req_t;

   typedef struct {
      logic [31:0] w;
      logic [1:0]  e;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  imm_src = '0;
   logic [6:0]  opcode = '0;
   logic [4:0]  rd = '0;
   logic [4:0]  rs1 = '0;
   logic [4:0]  rs2 = '0;
   logic [2:0]  funct3 = '0;
   logic [31:0] imm = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] instr;
   logic [1:0]  err;
`ifdef IMM_ENC_ERR_COUNT_EN
   logic [15:0] err_cnt;
   int          exp_cnt = 0;
`endif

   int   n_vec  = 0;
   int   n_fail = 0;
   bit   rdy_rand = 1'b0;
   exp_t q[$];

   imm_instr_encoder dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .imm_src   (imm_src),
      .opcode    (opcode),
      .rd        (rd),
      .rs1       (rs1),
      .rs2       (rs2),
      .funct3    (funct3),
      .imm       (imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .instr     (instr),
      .err       (err)
`ifdef IMM_ENC_ERR_COUNT_EN
      ,
      .err_cnt   (err_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Reference: ranges as signed intervals, fields placed with shifts and masks.
   function automatic exp_t model(input req_t r);
      exp_t x;
      logic signed [31:0] s;
      bit rng;
      bit mis;
      s   = r.imm;
      rng = 1'b0;
      mis = 1'b0;
      x.w = 32'h0;
      case (r.src)
         3'd0: begin
            rng = (s < -2048) || (s > 2047);
            x.w = ((r.imm & 32'hFFF) << 20) | (32'(r.rs1) << 15) | (32'(r.f3) << 12)
                  | (32'(r.rd) << 7) | 32'(r.op);
         end
         3'd1: begin
            rng = (s < -2048) || (s > 2047);
            x.w = (((r.imm >> 5) & 32'h7F) << 25) | (32'(r.rs2) << 20) | (32'(r.rs1) << 15)
                  | (32'(r.f3) << 12) | ((r.imm & 32'h1F) << 7) | 32'(r.op);
         end
         3'd3: begin
            rng = (s < -4096) || (s > 4095);
            mis = (r.imm % 2) != 0;
            x.w = (((r.imm >> 12) & 1) << 31) | (((r.imm >> 5) & 32'h3F) << 25)
                  | (32'(r.rs2) << 20) | (32'(r.rs1) << 15) | (32'(r.f3) << 12)
                  | (((r.imm >> 1) & 32'hF) << 8) | (((r.imm >> 11) & 1) << 7) | 32'(r.op);
         end
         3'd4: begin
            rng = (r.imm % 4096) != 0;
            x.w = (r.imm & 32'hFFFFF000) | (32'(r.rd) << 7) | 32'(r.op);
         end
         3'd2: begin
            rng = (s < -(1 << 20)) || (s > (1 << 20) - 1);
            mis = (r.imm % 2) != 0;
            x.w = (((r.imm >> 20) & 1) << 31) | (((r.imm >> 1) & 32'h3FF) << 21)
                  | (((r.imm >> 11) & 1) << 20) | (((r.imm >> 12) & 32'hFF) << 12)
                  | (32'(r.rd) << 7) | 32'(r.op);
         end
         default: ;
      endcase
      if (r.src > 3'd4) x.e = 2'd3;
      else if (rng)     x.e = 2'd1;
      else if (mis)     x.e = 2'd2;
      else              x.e = 2'd0;
      return x;
   endfunction

   function automatic req_t mk(input logic [2:0] src, input logic [6:0] op, input logic [4:0] rd_v,
                               input logic [4:0] rs1_v, input logic [4:0] rs2_v,
                               input logic [2:0] f3, input logic [31:0] iv);
      req_t r;
      r.src = src; r.op = op; r.rd = rd_v; r.rs1 = rs1_v; r.rs2 = rs2_v; r.f3 = f3; r.imm = iv;
      return r;
   endfunction

   function automatic req_t rand_req();
      req_t r;
      r.src = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      r.op  = 7'($urandom);
      r.rd  = 5'($urandom);
      r.rs1 = 5'($urandom);
      r.rs2 = 5'($urandom);
      r.f3  = 3'($urandom);
      case ($urandom_range(0, 3))
         0:       r.imm = $urandom;
         1:       r.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
         2:       r.imm = (32'($urandom_range(0, 32'h1FFFFF)) - 32'h100000) & ~32'h1;
         default: r.imm = $urandom & 32'hFFFFF000;
      endcase
      return r;
   endfunction

   // Called just after a rising edge; returns just after the edge that accepted (or gave up).
   task automatic send(input req_t r, input exp_t x, input int budget, output bit ok);
      bit acc;
      imm_src = r.src; opcode = r.op; rd = r.rd; rs1 = r.rs1; rs2 = r.rs2;
      funct3 = r.f3; imm = r.imm;
      in_valid = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < budget && !ok; c++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         if (acc) begin
            ok = 1'b1;
            q.push_back(x);
         end
      end
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_chk(input req_t r, input exp_t x);
      bit ok;
      send(r, x, 100, ok);
      n_vec++;
      if (!ok) begin
         n_fail++;
         $display("FAIL accept_timeout: request not accepted, src=%0d imm=%h", r.src, r.imm);
      end
   endtask

   task automatic drain();
      for (int c = 0; c < 200 && q.size() > 0; c++) @(posedge clk);
      #1;
      n_vec++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout: %0d outputs still pending, want 0", q.size());
      end
   endtask

   task automatic chk1(input string nm, input logic got, input logic want);
      n_vec++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %b want %b", nm, got, want);
      end
   endtask

   // Monitor: compares the head of the scoreboard every cycle out_valid is up, pops on transfer.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
`ifdef IMM_ENC_ERR_COUNT_EN
            n_vec++;
            if (err_cnt !== 16'(exp_cnt)) begin
               n_fail++;
               $display("FAIL err_cnt: got %0d want %0d", err_cnt, exp_cnt);
            end
`endif
            if (out_valid === 1'b1) begin
               n_vec++;
               if (q.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_output: instr=%h err=%0d with empty scoreboard", instr, err);
               end else begin
                  if (instr !== q[0].w || err !== q[0].e) begin
                     n_fail++;
                     $display("FAIL output: got instr=%h err=%0d want instr=%h err=%0d",
                              instr, err, q[0].w, q[0].e);
                  end
                  if (out_ready) begin
`ifdef IMM_ENC_ERR_COUNT_EN
                     if (q[0].e != 2'd0 && exp_cnt != 65535) exp_cnt++;
`endif
                     void'(q.pop_front());
                  end
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      exp_t  x;
      req_t  r;
      bit    ok_a, ok_b, ok_c;

      #1;
      chk1("reset_in_ready", in_ready, 1'b1);
      chk1("reset_out_valid", out_valid, 1'b0);
      n_vec++;
      if (instr !== 32'h0 || err !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got instr=%h err=%0d want 0/0", instr, err);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;

      // I-format with latency check
      x.w = 32'hFFF00093; x.e = 2'd0;
      send_chk(mk(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFF), x);
      @(negedge clk);
      chk1("latency_cycle1", out_valid, 1'b0);
      @(negedge clk);
      chk1("latency_cycle2", out_valid, 1'b1);
      @(posedge clk);
      #1;

      x.w = 32'h0021A423; x.e = 2'd0;
      send_chk(mk(3'd1, 7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 32'd8), x);
      x.w = 32'hFE000EE3; x.e = 2'd0;
      send_chk(mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFC), x);
      x.w = 32'h001000EF; x.e = 2'd0;
      send_chk(mk(3'd2, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h800), x);

      r = mk(3'd0, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 32'h1000);
      x = model(r); x.e = 2'd1;
      send_chk(r, x);
      r = mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3);
      x = model(r); x.e = 2'd2;
      send_chk(r, x);
      x.w = 32'h0; x.e = 2'd3;
      send_chk(mk(3'b110, 7'h33, 5'd4, 5'd5, 5'd6, 3'd1, 32'h5), x);
      drain();
`ifdef IMM_ENC_ERR_COUNT_EN
      n_vec++;
      if (err_cnt !== 16'd3) begin
         n_fail++;
         $display("FAIL err_cnt_after_errors: got %0d want 3", err_cnt);
      end
`endif

      // Backpressure: two held, third refused, then in-order drain
      out_ready = 1'b0;
      r = rand_req(); send(r, model(r), 4, ok_a);
      r = rand_req(); send(r, model(r), 4, ok_b);
      r = rand_req(); send(r, model(r), 4, ok_c);
      n_vec++;
      if (32'(ok_a) + 32'(ok_b) + 32'(ok_c) != 2) begin
         n_fail++;
         $display("FAIL bp_accepts: got %0d want 2", 32'(ok_a) + 32'(ok_b) + 32'(ok_c));
      end
      chk1("bp_in_ready", in_ready, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      out_ready = 1'b1;
      send_chk(r, model(r));
      drain();

      // Randomized traffic with random backpressure
      rdy_rand = 1'b1;
      for (int i = 0; i < 300; i++) begin
         r = rand_req();
         send_chk(r, model(r));
         if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      rdy_rand = 1'b0;
      out_ready = 1'b1;
      drain();

      // Reset with both stages full
      out_ready = 1'b0;
      r = rand_req(); send_chk(r, model(r));
      r = rand_req(); send_chk(r, model(r));
      @(posedge clk);
      #1;
      rst = 1'b1;
      q.delete();
`ifdef IMM_ENC_ERR_COUNT_EN
      exp_cnt = 0;
`endif
      #1;
      chk1("midreset_out_valid", out_valid, 1'b0);
      chk1("midreset_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      r = mk(3'd4, 7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 32'hABCDE000);
      x.w = 32'hABCDE3B7; x.e = 2'd0;
      send(r, x, 1, ok_a);
      chk1("post_reset_first_accept", ok_a, 1'b1);
      @(negedge clk);
      chk1("post_reset_lat1", out_valid, 1'b0);
      @(negedge clk);
      chk1("post_reset_lat2", out_valid, 1'b1);
      @(posedge clk);
      #1;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
